// File: rtl/de_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// Captures the engine result on start, iterates once per bit, then
// presents packed BCD digits with a one-cycle done_tick.
module de_bcd_converter #(
  parameter int W      = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          bin_in,
  input  logic                  start,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    bin_shift;
  logic [BW-1:0]   bcd_work;
  logic [BW-1:0]   bcd_adj;
  logic [BW+W-1:0] shifted;
  logic [CW-1:0]   cnt;
  logic            last_iter;

  // One double-dabble step: correct every digit above 4, then shift left.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] > 4'd4) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj[BW-2:0], bin_shift, 1'b0};
  end

  // The W-th iteration is the one taken while the counter holds W-1.
  assign last_iter = (cnt == CW'(W - 1));

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    ready      = 1'b0;
    done_tick  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = OP;
      end
      OP: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done_tick  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      bin_shift <= '0;
      bcd_work  <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            bin_shift <= bin_in;
            bcd_work  <= '0;
            cnt       <= '0;
          end
        end
        OP: begin
          {bcd_work, bin_shift} <= shifted;
          cnt                   <= cnt + 1'b1;
          if (last_iter) bcd_out <= shifted[BW+W-1:W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_de_bcd_converter.sv
// Self-checking bench for de_bcd_converter: expected BCD words are queued
// when a start is accepted and compared when done_tick appears.
module tb_de_bcd_converter;

  localparam int W      = 13;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [W-1:0]        bin_in;
  logic                ready;
  logic                done_tick;
  logic [4*DIGITS-1:0] bcd_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] sb[$];
  int          done_times[$];
  logic [15:0] mon_exp;

  de_bcd_converter #(.W(W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .start     (start),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd_out   (bcd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Decimal reference model: digit-by-digit division.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Scoreboard consumer: every done_tick must match the oldest request.
  always @(negedge clk) begin
    if (reset === 1'b0 && done_tick === 1'b1) begin
      n_checks++;
      done_times.push_back(cyc);
      if (sb.size() == 0) begin
        $display("FAIL done_value: unexpected done_tick, bcd_out=%h, no request pending", bcd_out);
      end else begin
        mon_exp = sb.pop_front();
        if (bcd_out !== mon_exp)
          $display("FAIL done_value: bcd_out=%h required %h", bcd_out, mon_exp);
        else
          n_pass++;
      end
    end
  end

  // Request a conversion: called at a negedge, returns one negedge after the
  // accepting rising edge.
  task automatic go(input int v);
    bin_in = W'(v);
    start  = 1'b1;
    sb.push_back(to_bcd(v));
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Count negedges after the start edge until done_tick is seen (bounded).
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done_tick !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", ready); else n_pass++;
    if (done_tick !== 1'b0) $display("FAIL reset_done: got %b required 0", done_tick); else n_pass++;
    if (bcd_out !== 16'h0000) $display("FAIL reset_bcd: got %h required 0000", bcd_out); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) $display("FAIL idle_ready: got %b required 1", ready); else n_pass++;
  endtask

  task automatic test_basic;
    int lat;
    go(5);
    n_checks++;
    if (ready !== 1'b0) $display("FAIL op_ready: got %b required 0", ready); else n_pass++;
    wait_done(1, lat);
    n_checks++;
    if (lat !== 14) $display("FAIL latency: got %0d cycles required 14", lat); else n_pass++;
    @(negedge clk);
    n_checks += 3;
    if (done_tick !== 1'b0) $display("FAIL done_width: got %b required 0", done_tick); else n_pass++;
    if (ready !== 1'b1) $display("FAIL ready_after_done: got %b required 1", ready); else n_pass++;
    if (bcd_out !== 16'h0005) $display("FAIL hold_5: got %h required 0005", bcd_out); else n_pass++;
  endtask

  task automatic test_sequence;
    int lat;
    bit stable;
    go(19);
    wait_done(1, lat);
    @(negedge clk);
    go(10);
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bcd_out !== 16'h0019) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable) $display("FAIL hold_during_op: bcd_out changed, last %h required 0019", bcd_out); else n_pass++;
    wait_done(13, lat);
    n_checks++;
    if (lat !== 14) $display("FAIL latency_seq: got %0d cycles required 14", lat); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_boundaries;
    int vals[4] = '{8191, 0, 999, 1000};
    int lat;
    for (int k = 0; k < 4; k++) begin
      go(vals[k]);
      wait_done(1, lat);
      n_checks++;
      if (lat !== 14) $display("FAIL latency_bound_%0d: got %0d cycles required 14", vals[k], lat); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start;
    int lat;
    int extra;
    go(100);
    repeat (3) @(negedge clk);
    bin_in = W'(200);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(5, lat);
    n_checks++;
    if (lat !== 14) $display("FAIL latency_ignored: got %0d cycles required 14", lat); else n_pass++;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_tick === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL ignored_start: got %0d extra done_tick required 0", extra); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int lat;
    int stray;
    go(77);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    n_checks += 3;
    if (ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", ready); else n_pass++;
    if (bcd_out !== 16'h0000) $display("FAIL abort_bcd: got %h required 0000", bcd_out); else n_pass++;
    if (done_tick !== 1'b0) $display("FAIL abort_done: got %b required 0", done_tick); else n_pass++;
    stray = 0;
    repeat (16) begin
      @(negedge clk);
      if (done_tick === 1'b1) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL abort_no_done: got %0d done_tick required 0", stray); else n_pass++;
    go(33);
    wait_done(1, lat);
    n_checks++;
    if (lat !== 14) $display("FAIL latency_after_abort: got %0d cycles required 14", lat); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int vals[3] = '{5, 10, 19};
    int acc[3];
    int w;
    int base;
    done_times.delete();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (ready !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      bin_in = W'(vals[k]);
      sb.push_back(to_bcd(vals[k]));
      acc[k] = cyc;
      @(negedge clk);
    end
    start = 1'b0;
    w = 0;
    while (done_times.size() < 3 && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (done_times.size() !== 3)
      $display("FAIL b2b_count: got %0d done_tick required 3", done_times.size());
    else
      n_pass++;
    for (int k = 1; k < 3; k++) begin
      n_checks++;
      if (acc[k] - acc[k-1] !== 15)
        $display("FAIL b2b_accept_%0d: spacing %0d required 15", k, acc[k] - acc[k-1]);
      else
        n_pass++;
    end
    base = (done_times.size() == 3) ? 1 : 3;
    for (int k = base; k < 3; k++) begin
      n_checks++;
      if (done_times[k] - done_times[k-1] !== 15)
        $display("FAIL b2b_done_%0d: spacing %0d required 15", k, done_times[k] - done_times[k-1]);
      else
        n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_boundaries();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
